wb_cmd_master: RTL
==================

// Module: wb_cmd_master
// PURPOSE
//   Wishbone initiator: turns a byte-stream command channel (e.g. from a UART receiver)
//   into single 8-bit Wishbone register reads/writes on the glitch register bank.
//   Returns one response byte per command on a byte-stream response channel.
//   Sits between the host link and the glitch register slave. Single clock domain.
// PARAMETERS
//   ADR_W    4    Wishbone address width; taken from cmd byte bits [ADR_W-1:0]
//   DAT_W    8    Wishbone/stream data width
//   TIMEOUT  255  Cycles stb_o may stay high without ack_i (used only with WBM_TIMEOUT_EN)
// PORTS
//   clk_i      in   1      system clock; all logic on posedge
//   rst_i      in   1      reset, asynchronous, active-high
//   cmd_data   in   DAT_W  command byte
//   cmd_valid  in   1      cmd_data valid
//   cmd_ready  out  1      byte accepted on a cycle where cmd_valid && cmd_ready
//   rsp_data   out  DAT_W  response byte
//   rsp_valid  out  1      rsp_data valid; held until taken
//   rsp_ready  in   1      sink accepts on a cycle where rsp_valid && rsp_ready
//   adr_o      out  ADR_W  Wishbone address
//   dat_o      out  DAT_W  Wishbone write data
//   dat_i      in   DAT_W  Wishbone read data; sampled on the ack_i cycle
//   we_o       out  1      1 = write cycle
//   stb_o      out  1      strobe
//   cyc_o      out  1      cycle; identical to stb_o (single transfers only)
//   ack_i      in   1      slave acknowledge
//   busy       out  1      high in every state except IDLE
// BEHAVIOUR
//   Command: byte0 [7]=we, [6:ADR_W] ignored, [ADR_W-1:0]=addr; if we=1, byte1 = write data.
//   Response: read -> dat_i captured at ack; write -> RSP_WR_OK (8'h06).
//   Reset: state IDLE; cmd_ready=0, rsp_valid=0, rsp_data=0, stb_o=cyc_o=we_o=0,
//     adr_o=dat_o=0, busy=0. Reset mid-cycle drops stb_o/cyc_o at once; in-flight cmd lost.
//   All outputs registered. cmd_ready=1 only in IDLE and GET_DATA.
//   FSM:
//   IDLE     : on byte0 handshake latch we/addr -> GET_DATA if we=1, else BUS.
//   GET_DATA : on byte1 handshake latch dat_o -> BUS.
//   BUS      : stb_o=cyc_o=1 from the cycle after the last command byte is accepted.
//              Entry deferred (stb_o held 0) while ack_i=1 (stale ack from previous cycle).
//              On ack_i=1: capture dat_i (reads), drop stb_o/cyc_o on that edge -> RESP.
//   RESP     : rsp_valid=1 from the cycle after ack; on rsp_ready -> IDLE, rsp_valid=0.
//   Latency: read cmd accepted at edge N -> stb_o high N+1; with slave ack at N+2,
//     rsp_valid high N+3. A slave with registered ack sees stb high for exactly 2 edges.
//   rsp_ready high continuously: rsp_valid lasts one cycle. cmd_valid outside
//     IDLE/GET_DATA: not accepted, byte held by source. adr/we/dat_o stable for whole BUS.
// CONFIGURATION
//   WBM_TIMEOUT_EN defined: counter clears on BUS entry, increments each BUS cycle;
//     at TIMEOUT cycles without ack_i: stb_o/cyc_o drop, rsp_data=RSP_TIMEOUT (8'h15),
//     -> RESP. ack_i on the same cycle as expiry wins (normal response).
//   Not defined: no counter; BUS waits for ack_i indefinitely; 8'h15 never produced.
// STRUCTURE
//   Package wbm_pkg: FSM state encoding (IDLE, GET_DATA, BUS, RESP), RSP_WR_OK,
//     RSP_TIMEOUT, CMD_WE_BIT=7.
//   Sub-module wbm_timeout_ctr (load/enable/expired), instantiated only under
//     WBM_TIMEOUT_EN. Everything else in wb_cmd_master.
// TESTING
//   1 Write: cmd 8'h81, 8'h3C; slave acks 1 cycle after stb -> adr_o=1, we_o=1,
//     dat_o=8'h3C for 2 cycles; rsp_data=8'h06; exactly one write at the slave.
//   2 Read: cmd 8'h02; slave returns 8'hA7 with ack -> rsp_data=8'hA7, we_o=0,
//     adr_o=2, stb_o high exactly 2 cycles.
//   3 Back-pressure: rsp_ready=0 for 10 cycles after read -> rsp_valid/rsp_data stable,
//     cmd_ready=0, next cmd byte not consumed until response taken.
//   4 Stale ack: slave holds ack_i=1 one extra cycle; back-to-back cmds -> second stb_o
//     rises only after ack_i low; no double-counted ack.
//   5 Timeout (WBM_TIMEOUT_EN, TIMEOUT=8): no ack -> stb_o drops after 8 cycles,
//     rsp_data=8'h15; next command completes normally.
//   6 Reset: rst_i asserted mid-BUS -> stb_o/cyc_o/busy low same cycle (async);
//     after release, cmd 8'h00 read completes normally.

Source files
------------

// File: rtl/wbm_pkg.sv
// Shared encodings for the Wishbone command master: FSM states, response codes
// and command-byte field positions.
package wbm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GET_DATA = 2'd1,
    ST_BUS      = 2'd2,
    ST_RESP     = 2'd3
  } wbm_state_e;

  localparam logic [7:0] RSP_WR_OK   = 8'h06;
  localparam logic [7:0] RSP_TIMEOUT = 8'h15;
  localparam int         CMD_WE_BIT  = 7;

endpackage

// File: rtl/wbm_timeout_ctr.sv
// Bus-cycle watchdog: down-counter reloaded while idle, terminal count flags expiry.
// Only instantiated when WBM_TIMEOUT_EN is defined.
module wbm_timeout_ctr #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load,
  input  logic enable,
  output logic expired
);

  // Holds TIMEOUT-1 so that expiry lands on the TIMEOUT-th enabled cycle.
  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CW'(TIMEOUT - 1);
    end else if (enable && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= CW'(TIMEOUT - 1);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/wb_cmd_master.sv
// Byte-stream command channel to single Wishbone read/write transfers, one response
// byte per command. Define WBM_TIMEOUT_EN to abort unacknowledged bus cycles.
//
// state    | meaning
// IDLE     | waiting for command byte 0 (we/addr)
// GET_DATA | write: waiting for the data byte
// BUS      | Wishbone cycle; strobe held off while a stale ack is still high
// RESP     | response byte presented until taken
module wb_cmd_master
  import wbm_pkg::*;
#(
  parameter int ADR_W   = 4,
  parameter int DAT_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [DAT_W-1:0] cmd_data,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  output logic [DAT_W-1:0] rsp_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [ADR_W-1:0] adr_o,
  output logic [DAT_W-1:0] dat_o,
  input  logic [DAT_W-1:0] dat_i,
  output logic             we_o,
  output logic             stb_o,
  output logic             cyc_o,
  input  logic             ack_i,
  output logic             busy
);

  wbm_state_e       state_q, state_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [DAT_W-1:0] rsp_data_q, rsp_data_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic [DAT_W-1:0] dat_q, dat_d;
  logic             we_q, we_d;
  logic             stb_q, stb_d;
  logic             busy_q, busy_d;
  logic             timed_out;
  logic             unused_cmd_bits;

  assign unused_cmd_bits = ^cmd_data[CMD_WE_BIT-1:ADR_W];

`ifdef WBM_TIMEOUT_EN
  logic tmo_expired;

  wbm_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout_ctr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load    (!stb_q),
    .enable  (stb_q),
    .expired (tmo_expired)
  );

  assign timed_out = stb_q & tmo_expired;
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT == 0);
  assign timed_out      = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    we_d        = we_q;
    stb_d       = stb_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          we_d  = cmd_data[CMD_WE_BIT];
          adr_d = cmd_data[ADR_W-1:0];
          if (cmd_data[CMD_WE_BIT]) begin
            state_d = ST_GET_DATA;
          end else begin
            state_d = ST_BUS;
            stb_d   = !ack_i;
          end
        end
      end
      ST_GET_DATA: begin
        if (cmd_valid && cmd_ready_q) begin
          dat_d   = cmd_data;
          state_d = ST_BUS;
          stb_d   = !ack_i;
        end
      end
      ST_BUS: begin
        if (!stb_q) begin
          stb_d = !ack_i;
        end else if (ack_i) begin
          // ack wins over a same-cycle timeout
          stb_d       = 1'b0;
          rsp_data_d  = we_q ? DAT_W'(RSP_WR_OK) : dat_i;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else if (timed_out) begin
          stb_d       = 1'b0;
          rsp_data_d  = DAT_W'(RSP_TIMEOUT);
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cmd_ready_d = (state_d == ST_IDLE) || (state_d == ST_GET_DATA);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      we_q        <= 1'b0;
      stb_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      we_q        <= we_d;
      stb_q       <= stb_d;
      busy_q      <= busy_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign adr_o     = adr_q;
  assign dat_o     = dat_q;
  assign we_o      = we_q;
  assign stb_o     = stb_q;
  assign cyc_o     = stb_q;
  assign busy      = busy_q;

endmodule
